// File: rtl/sub_serial_nbit.sv
// sub_serial_nbit: bit-serial n-bit subtractor computing a - b - borrow_in,
// one bit per clock, LSB first, with a start/done handshake.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      asynchronous active-low reset
//   start      request, sampled only in IDLE
//   a, b       minuend / subtrahend, latched on the accepting edge
//   borrow_in  initial borrow, latched on the accepting edge
//   busy       high while the subtraction is in progress
//   done       one-cycle pulse when diff/underflow hold a new result
//   diff       registered difference, (a - b - borrow_in) mod 2^BIT_WIDTH
//   underflow  registered final borrow-out (a < b + borrow_in, unsigned)
module sub_serial_nbit #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 underflow
);

    localparam int unsigned CNT_W = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [BIT_WIDTH-1:0] a_sh;
    logic [BIT_WIDTH-1:0] b_sh;
    logic [BIT_WIDTH-1:0] res_sh;
    logic                 br;
    logic [CNT_W-1:0]     cnt;

    logic                 d_bit;
    logic                 br_next;
    logic                 last_bit;
    logic [BIT_WIDTH-1:0] res_next;
    logic                 busy_next;
    logic                 done_next;

    // One full-subtractor slice on the current LSBs.
    always_comb begin
        d_bit    = a_sh[0] ^ b_sh[0] ^ br;
        br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        last_bit = (cnt == CNT_LAST);
        // Result bits enter at the MSB so the first (LSB) bit ends up at bit 0.
        res_next = {d_bit, res_sh[BIT_WIDTH-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode; busy/done are registered from the next state so they
    // line up exactly with the state they describe.
    always_comb begin
        busy_next = 1'b0;
        done_next = 1'b0;
        case (state_next)
            CALC:    busy_next = 1'b1;
            DONE:    done_next = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand/result shifters, borrow, bit counter and result outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            br        <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            diff      <= '0;
            underflow <= 1'b0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= borrow_in;
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    res_sh <= res_next;
                    if (last_bit) begin
                        diff      <= res_next;
                        underflow <= br_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_serial_nbit.sv
// Self-checking bench for sub_serial_nbit at BIT_WIDTH=4 and BIT_WIDTH=8.
module tb_sub_serial_nbit;

    logic       clk;
    logic       n_rst;

    logic       start4, bin4, busy4, done4, uf4;
    logic [3:0] a4, b4, diff4;

    logic       start8, bin8, busy8, done8, uf8;
    logic [7:0] a8, b8, diff8;

    int n_vec;
    int n_err;

    sub_serial_nbit #(.BIT_WIDTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .a(a4), .b(b4),
        .borrow_in(bin4), .busy(busy4), .done(done4), .diff(diff4),
        .underflow(uf4)
    );

    sub_serial_nbit #(.BIT_WIDTH(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8),
        .borrow_in(bin8), .busy(busy8), .done(done8), .diff(diff8),
        .underflow(uf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one 4-bit operation from IDLE and check latency, busy and result.
    task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb_,
                           input logic tbin, input string name);
        int          ia, ib, ic, lat, nbusy;
        logic [3:0]  ed, prev_diff;
        logic        eu, prev_uf;
        ia = int'(ta); ib = int'(tb_); ic = int'(tbin);
        ed = 4'(ia - ib - ic);
        eu = (ia < ib + ic);
        prev_diff = diff4;
        prev_uf   = uf4;
        a4 = ta; b4 = tb_; bin4 = tbin; start4 = 1'b1;
        step();
        start4 = 1'b0;
        lat = 0; nbusy = 0;
        while (!done4 && lat < 20) begin
            if (busy4) nbusy++;
            // Operands changing after acceptance must not matter.
            a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
            n_vec++;
            if (diff4 !== prev_diff || uf4 !== prev_uf) begin
                n_err++;
                $display("FAIL %s hold: diff=%h uf=%b during CALC, want %h %b",
                         name, diff4, uf4, prev_diff, prev_uf);
            end
            step();
            lat++;
        end
        n_vec++;
        if (lat !== 4 || nbusy !== 4) begin
            n_err++;
            $display("FAIL %s latency: edges=%0d busy_cycles=%0d, want 4 4", name, lat, nbusy);
        end
        n_vec++;
        if (diff4 !== ed || uf4 !== eu) begin
            n_err++;
            $display("FAIL %s result: a=%h b=%h bin=%b diff=%h uf=%b, want %h %b",
                     name, ta, tb_, tbin, diff4, uf4, ed, eu);
        end
        n_vec++;
        if (busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy_with_done: busy=%b, want 0", name, busy4);
        end
        step();
        n_vec++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            n_err++;
            $display("FAIL %s done_pulse: done=%b busy=%b one cycle later, want 0 0",
                     name, done4, busy4);
        end
    endtask

    // Same as run_op4 for the 8-bit instance (latency 8).
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
        int         ia, ib, ic, lat;
        logic [7:0] ed;
        logic       eu;
        ia = int'(ta); ib = int'(tb_); ic = int'(tbin);
        ed = 8'(ia - ib - ic);
        eu = (ia < ib + ic);
        a8 = ta; b8 = tb_; bin8 = tbin; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (!done8 && lat < 30) begin
            step();
            lat++;
        end
        n_vec++;
        if (lat !== 8 || diff8 !== ed || uf8 !== eu) begin
            n_err++;
            $display("FAIL w8 op: a=%h b=%h bin=%b edges=%0d diff=%h uf=%b, want 8 %h %b",
                     ta, tb_, tbin, lat, diff8, uf8, ed, eu);
        end
        step();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        start4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        start8 = 0; a8 = 0; b8 = 0; bin8 = 0;
        #23;
        n_vec++;
        if (busy4 !== 0 || done4 !== 0 || diff4 !== 4'h0 || uf4 !== 0 ||
            busy8 !== 0 || done8 !== 0 || diff8 !== 8'h00 || uf8 !== 0) begin
            n_err++;
            $display("FAIL reset_state: w4 busy=%b done=%b diff=%h uf=%b w8 busy=%b done=%b diff=%h uf=%b, want all 0",
                     busy4, done4, diff4, uf4, busy8, done8, diff8, uf8);
        end
        step();
        n_rst = 1'b1;
        step();
    endtask

    task automatic test_directed();
        run_op4(4'd7, 4'd3, 1'b0, "7-3");
        run_op4(4'd3, 4'd7, 1'b0, "3-7");
        run_op4(4'd0, 4'd0, 1'b1, "0-0-1");
        run_op4(4'hF, 4'hF, 1'b0, "F-F");
    endtask

    // Start held high with operands changing every cycle: one accept every 6 edges.
    task automatic test_back_to_back();
        logic [3:0] ra [0:35];
        logic [3:0] rb [0:35];
        logic       rc [0:35];
        logic [3:0] ed;
        logic       eu, eb, edn;
        int         ph;
        for (int c = 0; c < 36; c++) begin
            ra[c] = 4'($urandom); rb[c] = 4'($urandom); rc[c] = 1'($urandom);
            a4 = ra[c]; b4 = rb[c]; bin4 = rc[c]; start4 = 1'b1;
            step();
            ph  = c % 6;
            edn = (ph == 4);
            eb  = (ph <= 3);
            n_vec++;
            if (done4 !== edn || busy4 !== eb) begin
                n_err++;
                $display("FAIL b2b cycle %0d: done=%b busy=%b, want %b %b", c, done4, busy4, edn, eb);
            end
            if (ph == 4) begin
                ed = 4'(int'(ra[c-4]) - int'(rb[c-4]) - int'(rc[c-4]));
                eu = (int'(ra[c-4]) < int'(rb[c-4]) + int'(rc[c-4]));
                n_vec++;
                if (diff4 !== ed || uf4 !== eu) begin
                    n_err++;
                    $display("FAIL b2b result at %0d: diff=%h uf=%b, want %h %b", c, diff4, uf4, ed, eu);
                end
            end
        end
        start4 = 1'b0;
        step(); step();
    endtask

    // Reset mid-CALC after a result of 4 clears outputs and suppresses done.
    task automatic test_reset_mid_op();
        run_op4(4'd7, 4'd3, 1'b0, "pre_reset");
        a4 = 4'd9; b4 = 4'd2; bin4 = 1'b0; start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        #2 n_rst = 1'b0;
        #1;
        n_vec++;
        if (diff4 !== 4'h0 || uf4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: diff=%h uf=%b busy=%b done=%b, want 0 0 0 0",
                     diff4, uf4, busy4, done4);
        end
        step();
        n_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                n_err++;
                $display("FAIL mid_reset_quiet cycle %0d: done=%b busy=%b, want 0 0", i, done4, busy4);
            end
        end
        run_op4(4'd9, 4'd2, 1'b1, "post_reset");
    endtask

    task automatic test_sweep4();
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op4(4'(ia), 4'(ib), 1'(ic), "sweep");
    endtask

    task automatic test_random8();
        run_op8(8'h00, 8'h00, 1'b1);
        run_op8(8'hFF, 8'h00, 1'b0);
        for (int i = 0; i < 1000; i++)
            run_op8(8'($urandom), 8'($urandom), 1'($urandom));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_op();
        test_sweep4();
        test_random8();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
